userio_osd_ctrl: RTL
====================

# userio_osd_ctrl

Command sequencer for the OSD SPI slave. Decodes the byte stream delivered by the SPI slave (`rx`/`cmd`/`out`) into OSD buffer writes, configuration register writes and an OSD enable flag. It also supplies the slave's parallel `in` byte (ID / status readback). The block sits in the userio clock domain between the SPI slave and the OSD video buffer and control registers.

## Interface
- No parameters. Field widths are fixed by package constants.
- `clk` in 1: pixel clock.
- `_reset` in 1: asynchronous, active-low reset.
- `clk7_en` in 1: clock enable. All state advances only on `clk` edges with `clk7_en`=1.
- `spi_rx` in 1: byte-received strobe from the SPI slave. High for exactly one `clk7_en` sample per byte.
- `spi_cmd` in 1: qualifies `spi_rx`. 1 = first byte of the transaction (command).
- `spi_dat` in 8: received byte from the SPI slave.
- `spi_vld` in 1: synchronized chip-select active.
- `spi_tx` out 8: byte offered to the SPI slave `in` input.
- `buf_wr` out 1: OSD buffer write strobe.
- `buf_addr` out 11: OSD buffer address, laid out as {row[2:0], col[7:0]}.
- `buf_dat` out 8: OSD buffer write data.
- `cfg_wr` out 1: config register write strobe.
- `cfg_idx` out 3: config register index.
- `cfg_dat` out 8: config register data.
- `osd_enable` out 1: OSD display enable.
- `status_in` in 8: host status byte.
- `status_ack` out 1: status byte consumed.
- `cmd_err` out 1: unknown opcode strobe.

## Operation
- Opcode decode is done on `spi_dat` when `spi_rx`=1 and `spi_cmd`=1. A command byte always restarts decode, whatever the current state.
- `8'h20`–`8'h27`, WR_LINE: row = cmd[2:0], col = 0, go to state LINE.
  - In LINE, each data byte produces `buf_wr` with `buf_addr`={row,col} and `buf_dat`=byte, then col+1.
  - col wraps 255→0 and stays in the same row.
- `8'h40`/`8'h41`, OSD_CTL: `osd_enable`<=cmd[0], go to IGNORE.
- `8'h60`–`8'h67`, WR_CFG: `cfg_idx`<=cmd[2:0], go to CFG.
  - The first data byte produces `cfg_wr` with `cfg_dat`=byte, then go to IGNORE. Further bytes are dropped.
- `8'h80`, RD_STATUS: only with the macro enabled (see Configuration).
- `8'h00`, NOP: go to IGNORE.
- Any other opcode: `cmd_err` pulse, go to IGNORE.
- States: IDLE, LINE, CFG, STAT, IGNORE.
  - Data bytes received in IDLE or IGNORE are dropped.
- `spi_vld`=0 on a `clk7_en` sample forces IDLE and sets `spi_tx`=OSD_ID (`8'hA1`). This applies mid-transaction too: there are no partial writes and no strobes.
- If `spi_vld` falls on the same sample as `spi_rx`, the byte is processed first and IDLE is entered on the next sample.

## Timing
- All strobes (`buf_wr`, `cfg_wr`, `status_ack`, `cmd_err`) are registered:
  - Set on the `clk7_en` edge that samples `spi_rx`.
  - Cleared on the next `clk7_en` edge: one clk7 period wide.
- `buf_addr`, `buf_dat`, `cfg_idx`, `cfg_dat` are valid for the whole strobe period.
- col increments on the edge that clears `buf_wr`.
- `spi_tx` changes only on edges where `spi_rx`=1 or `spi_vld`=0. This keeps it stable for the slave's falling-edge load.
- Reset values:
  - `spi_tx`=`8'hA1`.
  - `buf_addr`=0, `buf_dat`=0.
  - `cfg_idx`=0, `cfg_dat`=0.
  - All strobes 0, `osd_enable`=0, state IDLE.
- Reset mid-operation aborts without any strobe.

## Configuration
- `OSD_READBACK_EN` defined: RD_STATUS is implemented.
  - On decode: `spi_tx`<=`status_in`, go to STAT.
  - Each data byte in STAT produces a `status_ack` pulse and reloads `spi_tx`<=`status_in`.
- `OSD_READBACK_EN` undefined:
  - `8'h80` is treated as unknown (`cmd_err`, IGNORE).
  - `status_ack` is tied 0.
  - `spi_tx` is only ever OSD_ID.

## Structure
- Shared package `userio_osd_pkg`:
  - Opcode constants OP_NOP, OP_WR_LINE, OP_OSD_CTL, OP_WR_CFG, OP_RD_STATUS, and their decode masks.
  - OSD_ID.
  - State enum.
  - Row/col widths.
- No sub-module; a single FSM plus address counter.

## Test plan
- Command `8'h23` followed by data `8'h41`, `8'h42`, `8'h43` → three `buf_wr` pulses at `buf_addr` `11'h300`, `11'h301`, `11'h302` with the matching `buf_dat`.
- Command `8'h25` followed by 257 data bytes → the 257th write lands at `11'h500` (col wrap, row unchanged).
- Command `8'h41`, then command `8'h40` → `osd_enable` goes 1, then 0. Neither command produces a strobe.
- Command `8'h62`, data `8'h5A`, data `8'hFF` → exactly one `cfg_wr` with `cfg_idx`=2 and `cfg_dat`=`8'h5A`.
- With `OSD_READBACK_EN` and `status_in`=`8'h3C`: command `8'h80` → `spi_tx`=`8'h3C`. One data byte → one `status_ack`. Without the macro: `cmd_err` pulse and `spi_tx` stays `8'hA1`.
- WR_LINE with `spi_vld` dropped after 1 byte, then command `8'h99` → one `buf_wr`, state IDLE, then one `cmd_err`. `_reset` asserted mid-LINE → all outputs at reset values immediately.

Source files
------------

// File: rtl/userio_osd_pkg.sv
// Shared constants, opcode table and state encoding for the OSD SPI command sequencer.
package userio_osd_pkg;

    localparam int ROW_W     = 3;
    localparam int COL_W     = 8;
    localparam int ADDR_W    = ROW_W + COL_W;
    localparam int CFG_IDX_W = 3;

    localparam logic [7:0] OSD_ID = 8'hA1;

    // Opcode values and the bits that must match for each opcode family
    localparam logic [7:0] OP_NOP            = 8'h00;
    localparam logic [7:0] OP_NOP_MASK       = 8'hFF;
    localparam logic [7:0] OP_WR_LINE        = 8'h20;
    localparam logic [7:0] OP_WR_LINE_MASK   = 8'hF8;
    localparam logic [7:0] OP_OSD_CTL        = 8'h40;
    localparam logic [7:0] OP_OSD_CTL_MASK   = 8'hFE;
    localparam logic [7:0] OP_WR_CFG         = 8'h60;
    localparam logic [7:0] OP_WR_CFG_MASK    = 8'hF8;
    localparam logic [7:0] OP_RD_STATUS      = 8'h80;
    localparam logic [7:0] OP_RD_STATUS_MASK = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        LINE,
        CFG,
        STAT,
        IGNORE
    } osd_state_e;

    function automatic logic opMatch(input logic [7:0] dat, input logic [7:0] op,
                                     input logic [7:0] mask);
        return (dat & mask) == op;
    endfunction

endpackage

// File: rtl/userio_osd_ctrl.sv
// Decodes the OSD SPI byte stream into buffer writes, config writes and the OSD enable.
// Optional status readback (opcode 8'h80) is built only when OSD_READBACK_EN is defined.
module userio_osd_ctrl
    import userio_osd_pkg::*;
(
    input  logic                 clk,
    input  logic                 _reset,
    input  logic                 clk7_en,
    input  logic                 spi_rx,
    input  logic                 spi_cmd,
    input  logic [7:0]           spi_dat,
    input  logic                 spi_vld,
    output logic [7:0]           spi_tx,
    output logic                 buf_wr,
    output logic [ADDR_W-1:0]    buf_addr,
    output logic [7:0]           buf_dat,
    output logic                 cfg_wr,
    output logic [CFG_IDX_W-1:0] cfg_idx,
    output logic [7:0]           cfg_dat,
    output logic                 osd_enable,
    input  logic [7:0]           status_in,
    output logic                 status_ack,
    output logic                 cmd_err
);

    osd_state_e           state_q, state_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [COL_W-1:0]     col_q, col_d, col_eff;
    logic [ADDR_W-1:0]    buf_addr_q, buf_addr_d;
    logic [7:0]           buf_dat_q, buf_dat_d;
    logic                 buf_wr_q, buf_wr_d;
    logic                 cfg_wr_q, cfg_wr_d;
    logic [CFG_IDX_W-1:0] cfg_idx_q, cfg_idx_d;
    logic [7:0]           cfg_dat_q, cfg_dat_d;
    logic                 osd_enable_q, osd_enable_d;
    logic [7:0]           spi_tx_q, spi_tx_d;
    logic                 cmd_err_q, cmd_err_d;

`ifdef OSD_READBACK_EN
    logic                 status_ack_q, status_ack_d;
    assign status_ack = status_ack_q;
`else
    logic                 unused_status;
    assign unused_status = ^status_in;
    assign status_ack    = 1'b0;
`endif

    // The column advances on the edge that retires a write, so a back-to-back byte sees it early
    assign col_eff = buf_wr_q ? col_q + 8'd1 : col_q;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_eff;
        buf_addr_d   = buf_addr_q;
        buf_dat_d    = buf_dat_q;
        buf_wr_d     = 1'b0;
        cfg_wr_d     = 1'b0;
        cfg_idx_d    = cfg_idx_q;
        cfg_dat_d    = cfg_dat_q;
        osd_enable_d = osd_enable_q;
        spi_tx_d     = spi_tx_q;
        cmd_err_d    = 1'b0;
`ifdef OSD_READBACK_EN
        status_ack_d = 1'b0;
`endif
        if (spi_rx) begin
            if (spi_cmd) begin
                if (opMatch(spi_dat, OP_WR_LINE, OP_WR_LINE_MASK)) begin
                    row_d   = spi_dat[ROW_W-1:0];
                    col_d   = '0;
                    state_d = LINE;
                end else if (opMatch(spi_dat, OP_OSD_CTL, OP_OSD_CTL_MASK)) begin
                    osd_enable_d = spi_dat[0];
                    state_d      = IGNORE;
                end else if (opMatch(spi_dat, OP_WR_CFG, OP_WR_CFG_MASK)) begin
                    cfg_idx_d = spi_dat[CFG_IDX_W-1:0];
                    state_d   = CFG;
                end else if (opMatch(spi_dat, OP_NOP, OP_NOP_MASK)) begin
                    state_d = IGNORE;
`ifdef OSD_READBACK_EN
                end else if (opMatch(spi_dat, OP_RD_STATUS, OP_RD_STATUS_MASK)) begin
                    spi_tx_d = status_in;
                    state_d  = STAT;
`endif
                end else begin
                    cmd_err_d = 1'b1;
                    state_d   = IGNORE;
                end
            end else begin
                case (state_q)
                    LINE: begin
                        buf_wr_d   = 1'b1;
                        buf_addr_d = {row_q, col_eff};
                        buf_dat_d  = spi_dat;
                    end
                    CFG: begin
                        cfg_wr_d  = 1'b1;
                        cfg_dat_d = spi_dat;
                        state_d   = IGNORE;
                    end
`ifdef OSD_READBACK_EN
                    STAT: begin
                        status_ack_d = 1'b1;
                        spi_tx_d     = status_in;
                    end
`endif
                    default: ;
                endcase
            end
        end else if (!spi_vld) begin
            state_d  = IDLE;
            spi_tx_d = OSD_ID;
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            buf_addr_q   <= '0;
            buf_dat_q    <= '0;
            buf_wr_q     <= 1'b0;
            cfg_wr_q     <= 1'b0;
            cfg_idx_q    <= '0;
            cfg_dat_q    <= '0;
            osd_enable_q <= 1'b0;
            spi_tx_q     <= OSD_ID;
            cmd_err_q    <= 1'b0;
`ifdef OSD_READBACK_EN
            status_ack_q <= 1'b0;
`endif
        end else if (clk7_en) begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            buf_addr_q   <= buf_addr_d;
            buf_dat_q    <= buf_dat_d;
            buf_wr_q     <= buf_wr_d;
            cfg_wr_q     <= cfg_wr_d;
            cfg_idx_q    <= cfg_idx_d;
            cfg_dat_q    <= cfg_dat_d;
            osd_enable_q <= osd_enable_d;
            spi_tx_q     <= spi_tx_d;
            cmd_err_q    <= cmd_err_d;
`ifdef OSD_READBACK_EN
            status_ack_q <= status_ack_d;
`endif
        end
    end

    assign spi_tx     = spi_tx_q;
    assign buf_wr     = buf_wr_q;
    assign buf_addr   = buf_addr_q;
    assign buf_dat    = buf_dat_q;
    assign cfg_wr     = cfg_wr_q;
    assign cfg_idx    = cfg_idx_q;
    assign cfg_dat    = cfg_dat_q;
    assign osd_enable = osd_enable_q;
    assign cmd_err    = cmd_err_q;

endmodule
